instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Owns the program counter and drives fetches into instruction memory over a valid/ready
// request + response interface. Queues fetched {pc, instr} pairs for decode. Consumes the
// branch outcome from execute: taken = branch && zero, target = ex_pc + (ex_imm << 1).
// On a taken branch it redirects the PC and flushes wrong-path work. Sits between the
// next-PC datapath and the decode stage.
// PARAMETERS
// XLEN      64   address/PC width
// RESET_PC  0    PC value loaded by reset
// FQ_DEPTH  2    fetch queue entries; power of two, >= 2
// PORTS
// clk             in   1     single clock, rising edge
// reset           in   1     asynchronous, active-high
// imem_req_valid  out  1     fetch request valid
// imem_req_ready  in   1     memory accepts request
// imem_req_addr   out  XLEN  fetch address (current PC)
// imem_rsp_valid  in   1     response valid; one response per accepted request, in order
// imem_rsp_data   in   32    fetched instruction word
// ex_branch       in   1     execute stage holds a branch
// ex_zero         in   1     ALU zero flag for that branch
// ex_pc           in   XLEN  PC of the branch
// ex_imm          in   XLEN  branch immediate, halfword units
// if_valid        out  1     fetch queue head valid
// if_ready        in   1     decode consumes head
// if_pc           out  XLEN  PC of head instruction
// if_instr        out  32    head instruction
// fetch_misalign  out  1     1-cycle pulse: taken target with target[1:0] != 0
// BEHAVIOUR
// - Reset (async assert, sync release): pc=RESET_PC, state=FETCH, queue empty; outputs
//   imem_req_valid=0, if_valid=0, fetch_misalign=0, if_pc/if_instr=0, imem_req_addr=RESET_PC.
// - At most one outstanding request. States: FETCH, WAIT, DROP.
// - FETCH: imem_req_valid = (count < FQ_DEPTH); addr = pc. On valid&&ready: req_pc<=pc,
//   pc<=pc+4 (mod 2^XLEN), -> WAIT. Addr held stable while valid && !ready.
// - WAIT: on imem_rsp_valid push {req_pc, imem_rsp_data}, -> FETCH. Request issued again
//   no earlier than the cycle after the response (fetch throughput 1 instr / 2 cycles min).
// - DROP: on imem_rsp_valid discard data, -> FETCH.
// - Redirect (ex_branch && ex_zero), takes priority over all other updates that cycle:
//   pc<=target; queue cleared at next edge (same-cycle pop and push discarded);
//   FETCH with handshake -> DROP; FETCH w/o handshake -> stay FETCH, next addr = target;
//   WAIT, rsp not valid -> DROP; WAIT, rsp valid -> FETCH, response discarded;
//   DROP, rsp not valid -> stay DROP; DROP, rsp valid -> FETCH.
// - Target arithmetic: XLEN-bit add, ex_imm << 1 truncated to XLEN, overflow wraps.
//   Misaligned target still loaded into pc; fetch_misalign pulses the following cycle.
// - Queue: if_valid = !empty; pop on if_valid && if_ready. Push never hits full (issue gated
//   on count < FQ_DEPTH). Push+pop same cycle: count unchanged. Head outputs registered.
// - Redirect cycle: head still visible; decode/execute squash it themselves.
// - Reset mid-transaction: state and queue cleared; a late response arriving in FETCH with
//   no outstanding request is ignored.
// STRUCTURE
// - riscv_fetch_pkg: fetch_state_t enum {FETCH, WAIT, DROP}; INSTR_W=32; PC_STEP=4;
//   fetch_entry_t struct {pc, instr}.
// - Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, depth FQ_DEPTH, push/pop/
//   flush, count output. Remaining PC/FSM logic inline in instr_fetch_unit.
// TESTING
// 1 Reset, ready=1, 1-cycle rsp latency, if_ready=1 -> addrs 0,4,8,C; if_pc matches, in order.
// 2 if_ready=0, FQ_DEPTH=2 -> exactly 2 entries queued, then imem_req_valid stays 0; release
//   if_ready -> fetch resumes at 0x8.
// 3 imem_req_ready low 3 cycles -> addr held at same value, pc advances only on accept.
// 4 WAIT at addr 0x10, branch ex_pc=0x8 ex_imm=0x20 zero=1 -> next req addr 0x48; late
//   response for 0x10 dropped; queue empty then 0x48 first.
// 5 Redirect same cycle as rsp_valid in WAIT -> response discarded, next req addr = target;
//   ex_branch=1 ex_zero=0 -> no redirect.
// 6 ex_imm=0x1 -> target ex_pc+2, fetch_misalign pulses 1 cycle; ex_pc=2^64-4, ex_imm=2 ->
//   target 0x0; reset asserted in WAIT -> req_valid=0 and if_valid=0 immediately.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The queue entry is sized to the default 64-bit PC width.
package riscv_fetch_pkg;

  localparam int unsigned XLEN_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branch immediate is in halfword units; the shift and add both wrap at XLEN_W bits.
  function automatic logic [XLEN_W-1:0] branch_target(input logic [XLEN_W-1:0] pc,
                                                      input logic [XLEN_W-1:0] imm);
    return pc + (imm << 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs feeding decode.
// Flush wins over any push or pop in the same cycle.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic               valid,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

  // Issue is gated on occupancy upstream, so these indicate a broken caller.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && !pop && (count_q == CNT_W'(DEPTH))))
        else $error("fetch_queue: push while full");
      assert (!(pop && (count_q == '0)))
        else $error("fetch_queue: pop while empty");
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, single-outstanding imem request FSM and branch redirect handling.
// Fetched words are queued in fetch_queue for decode.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_W,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               ex_branch,
  input  logic               ex_zero,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    ex_imm,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               fetch_misalign
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             misalign_q;

  logic             redirect;
  logic [XLEN-1:0]  target;
  logic             handshake;
  logic             fq_push, fq_pop;
  logic [CNT_W-1:0] fq_count;
  fetch_entry_t     fq_push_data, fq_head;

  assign redirect  = ex_branch && ex_zero;
  assign target    = branch_target(ex_pc, ex_imm);

  // Gate on reset so the request drops the instant reset asserts.
  assign imem_req_valid = !reset && (state_q == FETCH) && (fq_count < CNT_W'(FQ_DEPTH));
  assign imem_req_addr  = pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    fq_push  = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (handshake) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(PC_STEP);
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = FETCH;
          fq_push = 1'b1;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // A request accepted or still in flight on the redirect cycle belongs to the wrong path.
    if (redirect) begin
      pc_d    = target;
      fq_push = 1'b0;
      unique case (state_q)
        FETCH:       state_d = handshake ? DROP : FETCH;
        WAIT, DROP:  state_d = imem_rsp_valid ? FETCH : DROP;
        default:     state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      misalign_q <= redirect && (target[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = misalign_q;

  assign fq_push_data.pc    = req_pc_q;
  assign fq_push_data.instr = imem_rsp_data;
  assign fq_pop             = if_valid && if_ready;

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .flush     (redirect),
    .head      (fq_head),
    .valid     (if_valid),
    .count     (fq_count)
  );

  assign if_pc    = fq_head.pc;
  assign if_instr = fq_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural imem with programmable latency, a scoreboard of
// accepted fetches checked against decode output, redirect vector table and corner sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        ex_branch = 1'b0;
  logic        ex_zero   = 1'b0;
  logic [63:0] ex_pc     = '0;
  logic [63:0] ex_imm    = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_misalign;

  int tests = 0;
  int fails = 0;
  int accept_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ex_branch      (ex_branch),
    .ex_zero        (ex_zero),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_misalign (fetch_misalign)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // Behavioural imem; deliberately not reset so late responses survive a DUT reset.
  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  always @(posedge clk) begin
    if (imem_rsp_valid) imem_rsp_valid <= 1'b0;
    if (mem_pend) begin
      if (mem_cnt > 1) begin
        mem_cnt <= mem_cnt - 1;
      end else begin
        mem_pend       <= 1'b0;
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mem_addr);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      if (mem_lat <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(imem_req_addr);
      end else begin
        mem_pend <= 1'b1;
        mem_cnt  <= mem_lat - 1;
        mem_addr <= imem_req_addr;
      end
    end
  end

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on decode handshake; redirect/reset discard everything.
  always @(negedge clk) begin
    exp_t e;
    if (reset || (ex_branch && ex_zero)) begin
      sb.delete();
    end else begin
      if (if_valid && if_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got pc 0x%0h, expected no entry", if_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", if_pc, e.pc);
          chk("sb_instr", {32'h0, if_instr}, {32'h0, e.instr});
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        sb.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
        accept_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    step();
    accept_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic wait_accept(input logic [63:0] exp_addr, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        seen = 1'b1;
        chk(name, imem_req_addr, exp_addr);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s: got no accepted request in 60 cycles, expected addr 0x%0h",
               name, exp_addr);
    end
    step();
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        mis;
  } br_vec_t;

  br_vec_t vecs[6];

  initial begin
    reset = 1'b1;

    vecs[0] = '{pc: 64'h8,                   imm: 64'h20,                  tgt: 64'h48,  mis: 1'b0};
    vecs[1] = '{pc: 64'h100,                 imm: 64'h1,                   tgt: 64'h102, mis: 1'b1};
    vecs[2] = '{pc: 64'hFFFF_FFFF_FFFF_FFFC, imm: 64'h2,                   tgt: 64'h0,   mis: 1'b0};
    vecs[3] = '{pc: 64'h1000,                imm: 64'hFFFF_FFFF_FFFF_FFF8, tgt: 64'hFF0, mis: 1'b0};
    vecs[4] = '{pc: 64'h0,                   imm: 64'h8000_0000_0000_0001, tgt: 64'h2,   mis: 1'b1};
    vecs[5] = '{pc: 64'h3,                   imm: 64'h0,                   tgt: 64'h3,   mis: 1'b1};

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_misalign", {63'h0, fetch_misalign}, 64'h0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_if_instr", {32'h0, if_instr}, 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);

    // 1: streaming fetch, 1-cycle latency
    step();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    mem_lat = 1;
    wait_accept(64'h0, "t1_addr0");
    wait_accept(64'h4, "t1_addr4");
    wait_accept(64'h8, "t1_addr8");
    wait_accept(64'hC, "t1_addrC");
    imem_req_ready = 1'b0;
    repeat (4) step();

    // 2: decode stalled, queue fills to depth then issue stops
    do_reset();
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("t2_accepts", 64'(accept_cnt), 64'd2);
    chk("t2_if_valid", {63'h0, if_valid}, 64'h1);
    chk("t2_req_valid", {63'h0, imem_req_valid}, 64'h0);
    step();
    if_ready = 1'b1;
    wait_accept(64'h8, "t2_resume");
    imem_req_ready = 1'b0;
    repeat (4) step();

    // 3: memory back-pressure holds the address
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("t3_hold_addr", imem_req_addr, 64'h0);
      step();
    end
    imem_req_ready = 1'b1;
    wait_accept(64'h0, "t3_accept0");
    wait_accept(64'h4, "t3_accept4");
    imem_req_ready = 1'b0;
    repeat (4) step();

    // 4: redirect while waiting on a slow response
    do_reset();
    imem_req_ready = 1'b1;
    mem_lat = 1;
    wait_accept(64'h0, "t4_a0");
    wait_accept(64'h4, "t4_a4");
    wait_accept(64'h8, "t4_a8");
    wait_accept(64'hC, "t4_aC");
    mem_lat = 6;
    wait_accept(64'h10, "t4_a10");
    imem_req_ready = 1'b0;
    ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 64'h8; ex_imm = 64'h20;
    step();
    ex_branch = 1'b0; ex_zero = 1'b0;
    @(negedge clk);
    chk("t4_drop_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("t4_flushed", {63'h0, if_valid}, 64'h0);
    repeat (7) step();
    @(negedge clk);
    chk("t4_late_dropped", {63'h0, if_valid}, 64'h0);
    chk("t4_back_fetch", {63'h0, imem_req_valid}, 64'h1);
    step();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    wait_accept(64'h48, "t4_target");
    imem_req_ready = 1'b0;
    repeat (4) step();

    // 5: redirect coincident with response; non-taken branch has no effect
    do_reset();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    wait_accept(64'h0, "t5_a0");
    imem_req_ready = 1'b0;
    for (int n = 0; n < 10 && !imem_rsp_valid; n++) step();
    ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 64'h200; ex_imm = 64'h40;
    step();
    ex_branch = 1'b0; ex_zero = 1'b0;
    @(negedge clk);
    chk("t5_rsp_discarded", {63'h0, if_valid}, 64'h0);
    chk("t5_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("t5_addr", imem_req_addr, 64'h280);
    step();
    ex_branch = 1'b1; ex_zero = 1'b0; ex_pc = 64'h400; ex_imm = 64'h10;
    step();
    ex_branch = 1'b0;
    @(negedge clk);
    chk("t5_not_taken", imem_req_addr, 64'h280);
    step();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    wait_accept(64'h280, "t5_a280");
    wait_accept(64'h284, "t5_a284");
    imem_req_ready = 1'b0;
    repeat (4) step();

    // 6a: redirect target arithmetic and misalign pulse
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = vecs[i].pc; ex_imm = vecs[i].imm;
      step();
      ex_branch = 1'b0; ex_zero = 1'b0;
      @(negedge clk);
      chk($sformatf("t6_target[%0d]", i), imem_req_addr, vecs[i].tgt);
      chk($sformatf("t6_misalign[%0d]", i), {63'h0, fetch_misalign}, {63'h0, vecs[i].mis});
      step();
      @(negedge clk);
      chk($sformatf("t6_mis_pulse[%0d]", i), {63'h0, fetch_misalign}, 64'h0);
      step();
    end

    // 6b: reset asserted while waiting, late response afterwards ignored
    do_reset();
    if_ready = 1'b0;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    wait_accept(64'h0, "t6_a0");
    mem_lat = 6;
    wait_accept(64'h4, "t6_a4");
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("t6_queued", {63'h0, if_valid}, 64'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("t6_rst_if_valid", {63'h0, if_valid}, 64'h0);
    step();
    step();
    reset = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("t6_late_ignored", {63'h0, if_valid}, 64'h0);
    chk("t6_addr_after_rst", imem_req_addr, 64'h0);
    step();
    mem_lat = 1;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    wait_accept(64'h0, "t6_post_a0");
    wait_accept(64'h4, "t6_post_a4");
    imem_req_ready = 1'b0;

    repeat (6) step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
